// File: rtl/sa_wresp_merge_channel.sv
// Slave-arbiter write-response merge: tracks AW commits, folds split B responses into one.
// Optional BID/head-ID checker enabled with `define WRESP_ID_CHECK_EN.
module sa_wresp_merge_channel #(
    parameter int MST_AMT         = 3,
    parameter int OUTSTANDING_AMT = 8,
    parameter int MAX_SPLIT       = 4,
    parameter int MST_ID_W        = $clog2(MST_AMT),
    parameter int SPLIT_W         = $clog2(MAX_SPLIT) + 1,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + $clog2(MST_AMT),
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                                ACLK_i,
    input  logic                                ARESETn_i,
    input  logic [TRANS_SLV_ID_W-1:0]           AW_AxID_i,
    input  logic [SPLIT_W-1:0]                  AW_split_cnt_i,
    input  logic                                AW_shift_en_i,
    output logic                                AW_stall_o,
    input  logic [TRANS_SLV_ID_W-1:0]           s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
    input  logic                                s_BVALID_i,
    output logic                                s_BREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  dsp_BRESP_o,
    output logic [MST_AMT-1:0]                  dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                  dsp_BREADY_i,
    output logic                                id_err_o
);

    localparam int PTR_W = $clog2(OUTSTANDING_AMT);

    localparam logic [TRANS_WR_RESP_W-1:0] RESP_OKAY   = TRANS_WR_RESP_W'(0);
    localparam logic [TRANS_WR_RESP_W-1:0] RESP_EXOKAY = TRANS_WR_RESP_W'(1);
    localparam logic [TRANS_WR_RESP_W-1:0] RESP_SLVERR = TRANS_WR_RESP_W'(2);
    localparam logic [TRANS_WR_RESP_W-1:0] RESP_DECERR = TRANS_WR_RESP_W'(3);

    function automatic logic [TRANS_WR_RESP_W-1:0] merge_resp(
        input logic [TRANS_WR_RESP_W-1:0] a,
        input logic [TRANS_WR_RESP_W-1:0] b
    );
        if (a == RESP_DECERR || b == RESP_DECERR)
            merge_resp = RESP_DECERR;
        else if (a == RESP_SLVERR || b == RESP_SLVERR)
            merge_resp = RESP_SLVERR;
        else if (a == RESP_OKAY || b == RESP_OKAY)
            merge_resp = RESP_OKAY;
        else
            merge_resp = RESP_EXOKAY;
    endfunction

    logic [SPLIT_W-1:0]         trk_split [OUTSTANDING_AMT];
    logic [TRANS_SLV_ID_W-1:0]  trk_id    [OUTSTANDING_AMT];
    logic [PTR_W:0]             wr_ptr;
    logic [PTR_W:0]             rd_ptr;
    logic                       trk_empty;
    logic                       trk_full;
    logic                       push;
    logic                       pop;

    logic [SPLIT_W-1:0]         head_split;
    logic [SPLIT_W-1:0]         head_split_eff;
    logic [TRANS_SLV_ID_W-1:0]  head_id;

    logic [SPLIT_W-1:0]         sub_cnt;
    logic                       sub_vld;
    logic [SPLIT_W-1:0]         sub_eff;
    logic [TRANS_WR_RESP_W-1:0] acc_resp;
    logic [TRANS_WR_RESP_W-1:0] new_resp;
    logic                       last;
    logic                       s_hs;

    logic [TRANS_SLV_ID_W-1:0]  out_id;
    logic [TRANS_WR_RESP_W-1:0] out_resp;
    logic                       out_valid;
    logic [MST_ID_W-1:0]        out_mst;
    logic                       out_hs;

    assign trk_empty = (wr_ptr == rd_ptr);
    assign trk_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push      = AW_shift_en_i & ~trk_full;
    assign pop       = s_hs & last;

    assign head_split     = trk_split[rd_ptr[PTR_W-1:0]];
    assign head_id        = trk_id[rd_ptr[PTR_W-1:0]];
    assign head_split_eff = (head_split == '0) ? SPLIT_W'(1) : head_split;

    // sub_vld low means the head was just exposed, so the count comes straight from the FIFO
    assign sub_eff  = sub_vld ? sub_cnt : head_split_eff;
    assign last     = (sub_eff == SPLIT_W'(1));
    assign new_resp = sub_vld ? merge_resp(acc_resp, s_BRESP_i) : s_BRESP_i;

    assign out_mst    = out_id[TRANS_SLV_ID_W-1 -: MST_ID_W];
    assign out_hs     = |(dsp_BVALID_o & dsp_BREADY_i);
    assign s_BREADY_o = ~trk_empty & (~last | ~out_valid | out_hs);
    assign s_hs       = s_BVALID_i & s_BREADY_o;
    assign AW_stall_o = trk_full;

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            trk_split[wr_ptr[PTR_W-1:0]] <= AW_split_cnt_i;
            trk_id[wr_ptr[PTR_W-1:0]]    <= AW_AxID_i;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            sub_cnt  <= '0;
            sub_vld  <= 1'b0;
            acc_resp <= RESP_OKAY;
        end else if (s_hs) begin
            if (last) begin
                sub_cnt  <= '0;
                sub_vld  <= 1'b0;
                acc_resp <= RESP_OKAY;
            end else begin
                sub_cnt  <= sub_eff - SPLIT_W'(1);
                sub_vld  <= 1'b1;
                acc_resp <= new_resp;
            end
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            out_id    <= '0;
            out_resp  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out_id    <= s_BID_i;
            out_resp  <= new_resp;
            out_valid <= 1'b1;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        dsp_BVALID_o = '0;
        dsp_BID_o    = '0;
        dsp_BRESP_o  = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            dsp_BVALID_o[i] = out_valid & (out_mst == MST_ID_W'(i));
            dsp_BID_o[i*TRANS_MST_ID_W +: TRANS_MST_ID_W] =
                out_id[TRANS_MST_ID_W-1:0];
            dsp_BRESP_o[i*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = out_resp;
        end
    end

`ifdef WRESP_ID_CHECK_EN
    logic id_err_q;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i)
            id_err_q <= 1'b0;
        else
            id_err_q <= s_hs & (s_BID_i != head_id);
    end

    assign id_err_o = id_err_q;
`else
    logic id_unused;

    assign id_unused = ^head_id;
    assign id_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sa_wresp_merge_channel.sv
// Directed + randomized bench for sa_wresp_merge_channel.
// Random phase is checked against a queue-based transaction model.
module tb_sa_wresp_merge_channel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  aw_id;
    logic [2:0]  aw_split;
    logic        aw_en;
    logic        aw_stall;
    logic [6:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [14:0] d_bid;
    logic [5:0]  d_bresp;
    logic [2:0]  d_bvalid;
    logic [2:0]  d_bready;
    logic        id_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] id;
        int         need;
        int         got;
        int         worst;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    sa_wresp_merge_channel dut (
        .ACLK_i         (clk),
        .ARESETn_i      (rst_n),
        .AW_AxID_i      (aw_id),
        .AW_split_cnt_i (aw_split),
        .AW_shift_en_i  (aw_en),
        .AW_stall_o     (aw_stall),
        .s_BID_i        (s_bid),
        .s_BRESP_i      (s_bresp),
        .s_BVALID_i     (s_bvalid),
        .s_BREADY_o     (s_bready),
        .dsp_BID_o      (d_bid),
        .dsp_BRESP_o    (d_bresp),
        .dsp_BVALID_o   (d_bvalid),
        .dsp_BREADY_i   (d_bready),
        .id_err_o       (id_err)
    );

    // Severity order EXOKAY < OKAY < SLVERR < DECERR
    function automatic int rank(input logic [1:0] r);
        case (r)
            2'd1:    return 0;
            2'd0:    return 1;
            2'd2:    return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] unrank(input int k);
        case (k)
            0:       return 2'd1;
            1:       return 2'd0;
            2:       return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] id, input logic [2:0] sp);
        aw_en    = 1'b1;
        aw_id    = id;
        aw_split = sp;
        tick();
        aw_en    = 1'b0;
    endtask

    task automatic b_send(input logic [6:0] id, input logic [1:0] r);
        int n;
        s_bvalid = 1'b1;
        s_bid    = id;
        s_bresp  = r;
        #1;
        n = 0;
        while (!s_bready && n < 20) begin
            tick();
            n++;
        end
        if (!s_bready)
            chk("bready_timeout", 32'(s_bready), 1);
        tick();
        s_bvalid = 1'b0;
    endtask

    initial begin
        logic [4:0] low;
        logic [1:0] exp_mst;
        logic [4:0] exp_id;
        logic [1:0] exp_resp;
        logic       exp_v;
        logic       full_b;
        ent_t       h;

        rst_n    = 1'b0;
        aw_en    = 1'b0;
        aw_id    = '0;
        aw_split = '0;
        s_bid    = '0;
        s_bresp  = '0;
        s_bvalid = 1'b0;
        d_bready = 3'b111;
        tick();
        tick();
        chk("rst_bready", 32'(s_bready), 0);
        chk("rst_bvalid", 32'(d_bvalid), 0);
        chk("rst_bid",    32'(d_bid), 0);
        chk("rst_bresp",  32'(d_bresp), 0);
        chk("rst_stall",  32'(aw_stall), 0);
        chk("rst_iderr",  32'(id_err), 0);
        rst_n = 1'b1;
        tick();

        // single unsplit
        push(7'h25, 3'd1);
        chk("t1_bready", 32'(s_bready), 1);
        b_send(7'h25, 2'd0);
        chk("t1_bvalid", 32'(d_bvalid), 32'(3'b010));
        chk("t1_bid",    32'(d_bid), 32'({3{5'h05}}));
        chk("t1_bresp",  32'(d_bresp), 0);
        tick();
        chk("t1_drop",   32'(d_bvalid), 0);

        // split merge OKAY, SLVERR, OKAY
        push(7'h0A, 3'd3);
        b_send(7'h0A, 2'd0);
        chk("t2_mid1", 32'(d_bvalid), 0);
        b_send(7'h0A, 2'd2);
        chk("t2_mid2", 32'(d_bvalid), 0);
        b_send(7'h0A, 2'd0);
        chk("t2_bvalid", 32'(d_bvalid), 32'(3'b001));
        chk("t2_bresp",  32'(d_bresp), 32'({3{2'd2}}));
        chk("t2_bid",    32'(d_bid), 32'({3{5'h0A}}));

        // EXOKAY rule
        push(7'h40, 3'd2);
        b_send(7'h40, 2'd1);
        b_send(7'h40, 2'd1);
        chk("t3_ex_valid", 32'(d_bvalid), 32'(3'b100));
        chk("t3_ex_resp",  32'(d_bresp), 32'({3{2'd1}}));
        push(7'h41, 3'd2);
        b_send(7'h41, 2'd1);
        b_send(7'h41, 2'd0);
        chk("t3_mix_resp", 32'(d_bresp), 32'({3{2'd0}}));
        chk("t3_mix_bid",  32'(d_bid), 32'({3{5'h01}}));
        tick();

        // full FIFO, ninth push dropped
        for (int k = 0; k < 8; k++)
            push(7'(8 + k), 3'd1);
        chk("t4_stall", 32'(aw_stall), 1);
        push(7'h3F, 3'd1);
        chk("t4_stall_hold", 32'(aw_stall), 1);
        b_send(7'h08, 2'd0);
        chk("t4_unstall", 32'(aw_stall), 0);
        chk("t4_first",   32'(d_bid), 32'({3{5'h08}}));
        for (int k = 1; k < 8; k++) begin
            b_send(7'(8 + k), 2'd3);
            low = 5'(8 + k);
            chk("t4_drain_bid",  32'(d_bid), 32'({3{low}}));
            chk("t4_drain_resp", 32'(d_bresp), 32'({3{2'd3}}));
        end
        chk("t4_empty", 32'(s_bready), 0);
        tick();

        // back-pressure, then reset with response held
        d_bready = 3'b000;
        push(7'h25, 3'd1);
        push(7'h26, 3'd1);
        b_send(7'h25, 2'd2);
        chk("t5_valid", 32'(d_bvalid), 32'(3'b010));
        s_bvalid = 1'b1;
        s_bid    = 7'h26;
        s_bresp  = 2'd0;
        #1;
        chk("t5_bready_lo", 32'(s_bready), 0);
        tick();
        tick();
        chk("t5_hold_valid", 32'(d_bvalid), 32'(3'b010));
        chk("t5_hold_bid",   32'(d_bid), 32'({3{5'h05}}));
        chk("t5_hold_resp",  32'(d_bresp), 32'({3{2'd2}}));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(d_bvalid), 0);
        chk("t5_rst_bready", 32'(s_bready), 0);
        chk("t5_rst_stall", 32'(aw_stall), 0);
        s_bvalid = 1'b0;
        tick();
        rst_n    = 1'b1;
        d_bready = 3'b111;
        tick();
        chk("t5_post_empty", 32'(s_bready), 0);
        chk("t5_post_valid", 32'(d_bvalid), 0);

`ifdef WRESP_ID_CHECK_EN
        push(7'h10, 3'd1);
        b_send(7'h11, 2'd0);
        chk("t6_iderr",  32'(id_err), 1);
        chk("t6_valid",  32'(d_bvalid), 32'(3'b001));
        chk("t6_bid",    32'(d_bid), 32'({3{5'h11}}));
        tick();
        chk("t6_iderr_end", 32'(id_err), 0);
`endif

        // randomized traffic against the queue model
        exp_v    = 1'b0;
        exp_mst  = '0;
        exp_id   = '0;
        exp_resp = '0;
        for (int c = 0; c < 400; c++) begin
            aw_en    = ($urandom_range(0, 9) < 4);
            aw_id    = 7'(($urandom_range(0, 2) << 5) | $urandom_range(0, 31));
            aw_split = 3'($urandom_range(0, 4));
            s_bvalid = 1'($urandom_range(0, 1));
            s_bresp  = 2'($urandom_range(0, 3));
            s_bid    = (q.size() != 0) ? q[0].id : 7'($urandom_range(0, 95));
            #1;
            chk("r_stall",  32'(aw_stall), 32'(q.size() == 8));
            chk("r_bready", 32'(s_bready), 32'(q.size() != 0));
            chk("r_dvalid", 32'(d_bvalid),
                exp_v ? 32'(3'b001 << exp_mst) : 32'd0);
            if (exp_v) begin
                chk("r_bid",   32'(d_bid), 32'({3{exp_id}}));
                chk("r_bresp", 32'(d_bresp), 32'({3{exp_resp}}));
            end
            chk("r_iderr", 32'(id_err), 0);

            full_b = (q.size() == 8);
            exp_v  = 1'b0;
            if (s_bvalid && q.size() != 0) begin
                h = q[0];
                h.got++;
                if (rank(s_bresp) > h.worst)
                    h.worst = rank(s_bresp);
                if (h.got >= h.need) begin
                    exp_v    = 1'b1;
                    exp_mst  = h.id[6:5];
                    exp_id   = h.id[4:0];
                    exp_resp = unrank(h.worst);
                    void'(q.pop_front());
                end else begin
                    q[0] = h;
                end
            end
            if (aw_en && !full_b) begin
                h.id    = aw_id;
                h.need  = (aw_split == 0) ? 1 : int'(aw_split);
                h.got   = 0;
                h.worst = -1;
                q.push_back(h);
            end
            tick();
        end
        aw_en    = 1'b0;
        s_bvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
